// File: rtl/moosic_key_ctrl_if.sv
// Handshake bundle between the key sequencer and its host.
// The host drives key loads and increment requests; the sequencer returns the armed key and status.
interface moosic_key_ctrl_if #(
  parameter int KEY_SIZE = 6
);
  logic                load_start;
  logic                bit_valid;
  logic                bit_data;
  logic                incr_req;
  logic [KEY_SIZE-1:0] key_out;
  logic                key_valid;
  logic                do_incr;
  logic                busy;
  logic                err;
  logic                lockout;

  modport master (
    output load_start, bit_valid, bit_data, incr_req,
    input  key_out, key_valid, do_incr, busy, err, lockout
  );

  modport slave (
    input  load_start, bit_valid, bit_data, incr_req,
    output key_out, key_valid, do_incr, busy, err, lockout
  );
endinterface

// File: rtl/moosic_key_ctrl.sv
// Key-load and increment sequencer for the moosic locked counter.
// Define MOOSIC_KEY_ZEROIZE_EN to clear key_out whenever no valid key is armed.
module moosic_key_ctrl #(
  parameter int KEY_SIZE    = 6,
  parameter int RETRY_LIMIT = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  moosic_key_ctrl_if.slave        bus
);

  localparam int CNT_W  = $clog2(KEY_SIZE + 2);
  localparam int FAIL_W = $clog2(RETRY_LIMIT + 1);

  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(KEY_SIZE);
  localparam logic [FAIL_W-1:0] RETRY_MAX = FAIL_W'(RETRY_LIMIT);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    CHECK   = 3'd2,
    ARMED   = 3'd3,
    LOCKOUT = 3'd4
  } state_e;

  state_e              state_q,   state_d;
  logic [KEY_SIZE:0]   sreg_q,    sreg_d;
  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  logic [FAIL_W-1:0]   fail_q,    fail_d;
  logic [KEY_SIZE-1:0] key_q,     key_d;
  logic                err_q,     err_d;
  logic                do_incr_q, do_incr_d;

  logic                parity_ok;
  logic [FAIL_W-1:0]   fail_inc;

  // Shift register holds key bits in [KEY_SIZE:1] and the parity bit in [0].
  assign parity_ok = ((^sreg_q[KEY_SIZE:1]) == sreg_q[0]);
  assign fail_inc  = (fail_q == RETRY_MAX) ? fail_q : fail_q + FAIL_W'(1);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d   = state_q;
    sreg_d    = sreg_q;
    cnt_d     = cnt_q;
    fail_d    = fail_q;
    key_d     = key_q;
    err_d     = 1'b0;
    do_incr_d = (state_q == ARMED) && bus.incr_req;

    unique case (state_q)
      IDLE: begin
        sreg_d = '0;
        cnt_d  = '0;
        if (bus.load_start) state_d = SHIFT;
      end
      ARMED: begin
        sreg_d = '0;
        cnt_d  = '0;
        if (bus.load_start) begin
          state_d = SHIFT;
`ifdef MOOSIC_KEY_ZEROIZE_EN
          key_d   = '0;
`endif
        end
      end
      SHIFT: begin
        if (bus.bit_valid) begin
          sreg_d = {sreg_q[KEY_SIZE-1:0], bus.bit_data};
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_IDX) state_d = CHECK;
        end
      end
      CHECK: begin
        if (parity_ok) begin
          key_d   = sreg_q[KEY_SIZE:1];
          fail_d  = '0;
          state_d = ARMED;
        end else begin
          err_d   = 1'b1;
          fail_d  = fail_inc;
`ifdef MOOSIC_KEY_ZEROIZE_EN
          key_d   = '0;
`endif
          state_d = (fail_inc == RETRY_MAX) ? LOCKOUT : IDLE;
        end
      end
      LOCKOUT: ;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every register, the shift register included, is reset so an aborted load leaves no residue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      cnt_q     <= '0;
      fail_q    <= '0;
      key_q     <= '0;
      err_q     <= 1'b0;
      do_incr_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      cnt_q     <= cnt_d;
      fail_q    <= fail_d;
      key_q     <= key_d;
      err_q     <= err_d;
      do_incr_q <= do_incr_d;
    end
  end

  assign bus.key_out   = key_q;
  assign bus.key_valid = (state_q == ARMED);
  assign bus.do_incr   = do_incr_q;
  assign bus.busy      = (state_q == SHIFT) || (state_q == CHECK);
  assign bus.err       = err_q;
  assign bus.lockout   = (state_q == LOCKOUT);

endmodule

// File: tb/tb_moosic_key_ctrl.sv
// Directed scoreboard bench for moosic_key_ctrl: key loads, parity failures, lockout,
// increment gating and asynchronous reset.
module tb_moosic_key_ctrl;

  localparam int KS = 6;
  localparam int RL = 3;

`ifdef MOOSIC_KEY_ZEROIZE_EN
  localparam bit ZEROIZE = 1'b1;
`else
  localparam bit ZEROIZE = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  moosic_key_ctrl_if #(.KEY_SIZE(KS)) bus ();

  moosic_key_ctrl #(.KEY_SIZE(KS), .RETRY_LIMIT(RL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [KS-1:0] key;
    logic          good;
  } exp_load_t;

  exp_load_t load_q[$];
  logic      incr_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model of the sequencer's visible state.
  logic [KS-1:0] model_key   = '0;
  logic          model_armed = 1'b0;
  int            model_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    model_key   = '0;
    model_armed = 1'b0;
    model_fail  = 0;
    load_q.delete();
    incr_q.delete();
  endtask

  task automatic incr_step(input logic req);
    bus.incr_req = req;
    incr_q.push_back(model_armed && req);
    cycle();
    check("do_incr", bus.do_incr, incr_q.pop_front());
    bus.incr_req = 1'b0;
  endtask

  // Full key load; gap_a/gap_b insert a bit_valid=0 cycle before that key bit index (-1 = none).
  task automatic load_key(input logic [KS-1:0] key, input logic bad, input int gap_a,
                          input int gap_b, input logic incr_in_check, input logic incr_with_start);
    exp_load_t e;
    int        n;
    bus.load_start = 1'b1;
    bus.incr_req   = incr_with_start;
    incr_q.push_back(model_armed && incr_with_start);
    cycle();
    bus.load_start = 1'b0;
    bus.incr_req   = 1'b0;
    check("start_do_incr", bus.do_incr, incr_q.pop_front());
    if (model_armed && ZEROIZE) model_key = '0;
    model_armed = 1'b0;
    check("start_busy", bus.busy, 1'b1);
    check("start_kv_drop", bus.key_valid, 1'b0);

    e.key  = bad ? model_key : key;
    e.good = !bad;
    if (bad && ZEROIZE) e.key = '0;
    load_q.push_back(e);

    for (int i = KS - 1; i >= 0; i--) begin
      if (i == gap_a || i == gap_b) begin
        bus.bit_valid = 1'b0;
        incr_step(1'b1);
        check("stall_busy", bus.busy, 1'b1);
      end
      bus.bit_valid = 1'b1;
      bus.bit_data  = key[i];
      cycle();
      check("shift_err", bus.err, 1'b0);
    end
    check("key_during_load", bus.key_out, model_key);
    bus.bit_data = (^key) ^ bad;
    cycle();
    bus.bit_valid = 1'b0;
    bus.bit_data  = 1'b0;
    check("check_busy", bus.busy, 1'b1);
    check("check_kv", bus.key_valid, 1'b0);

    bus.incr_req = incr_in_check;
    n = 0;
    while (n < 4) begin
      cycle();
      n++;
      bus.incr_req = 1'b0;
      if (n == 1 && incr_in_check) check("incr_in_check_dropped", bus.do_incr, 1'b0);
      if (bus.key_valid || bus.err) break;
    end
    check("outcome_latency", n, 1);

    e = load_q.pop_front();
    check("outcome_key", bus.key_out, e.key);
    check("outcome_kv", bus.key_valid, e.good);
    check("outcome_err", bus.err, !e.good);
    check("outcome_busy", bus.busy, 1'b0);
    if (e.good) begin
      model_key   = key;
      model_armed = 1'b1;
      model_fail  = 0;
    end else begin
      model_key  = e.key;
      model_fail = model_fail + 1;
    end
    check("outcome_lockout", bus.lockout, (model_fail >= RL));
    if (!e.good) begin
      cycle();
      check("err_one_cycle", bus.err, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.load_start = 1'b0;
    bus.bit_valid  = 1'b0;
    bus.bit_data   = 1'b0;
    bus.incr_req   = 1'b0;

    #2;
    check("rst_key_out", bus.key_out, '0);
    check("rst_key_valid", bus.key_valid, 1'b0);
    check("rst_do_incr", bus.do_incr, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_err", bus.err, 1'b0);
    check("rst_lockout", bus.lockout, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    incr_step(1'b1);
    load_key(6'h2D, 1'b0, -1, -1, 1'b0, 1'b0);
    check("good_key_2d", bus.key_out, 6'h2D);

    for (int i = 0; i < 4; i++) incr_step(1'b1);
    incr_step(1'b0);

    load_key(6'h12, 1'b0, 4, 1, 1'b0, 1'b1);
    check("reload_key_12", bus.key_out, 6'h12);

    load_key(6'h2D, 1'b1, -1, -1, 1'b0, 1'b0);
    incr_step(1'b1);
    load_key(6'h2D, 1'b0, -1, -1, 1'b1, 1'b0);

    load_key(6'h2D, 1'b1, -1, -1, 1'b0, 1'b0);
    load_key(6'h15, 1'b1, -1, -1, 1'b0, 1'b0);
    load_key(6'h3F, 1'b1, -1, -1, 1'b0, 1'b0);
    check("lockout_set", bus.lockout, 1'b1);

    bus.load_start = 1'b1;
    bus.incr_req   = 1'b1;
    incr_q.push_back(1'b0);
    cycle();
    cycle();
    bus.load_start = 1'b0;
    bus.incr_req   = 1'b0;
    check("lock_do_incr", bus.do_incr, incr_q.pop_front());
    check("lock_busy", bus.busy, 1'b0);
    check("lock_kv", bus.key_valid, 1'b0);
    check("lock_held", bus.lockout, 1'b1);

    #2 rst_n = 1'b0;
    #1;
    check("async_rst_lockout", bus.lockout, 1'b0);
    check("async_rst_busy", bus.busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cycle();

    load_key(6'h2D, 1'b0, -1, -1, 1'b0, 1'b0);
    bus.load_start = 1'b1;
    cycle();
    bus.load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.bit_valid = 1'b1;
      bus.bit_data  = i[0];
      cycle();
    end
    check("mid_shift_busy", bus.busy, 1'b1);
    #2 rst_n = 1'b0;
    bus.bit_valid = 1'b0;
    bus.bit_data  = 1'b0;
    #1;
    check("mid_rst_key_out", bus.key_out, '0);
    check("mid_rst_kv", bus.key_valid, 1'b0);
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_err", bus.err, 1'b0);
    check("mid_rst_do_incr", bus.do_incr, 1'b0);
    check("mid_rst_lockout", bus.lockout, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cycle();

    load_key(6'h12, 1'b0, -1, -1, 1'b0, 1'b0);
    check("fresh_key_12", bus.key_out, 6'h12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
